// File: rtl/adc_frame_packer_64_pkg.sv
// Shared definitions for the ADC frame packer: FSM states, header magic and
// the words-per-frame derivation used by both the RTL and host-side models.
package adc_frame_packer_64_pkg;

  localparam logic [15:0] HEADER_MAGIC = 16'hADC0;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_HEADER      = 2'd1,
    ST_WAIT_SAMPLE = 2'd2,
    ST_DATA        = 2'd3
  } state_e;

  function automatic int words_per_frame(input int n_chan, input int chan_width,
                                         input int data_width);
    return (n_chan * chan_width) / data_width;
  endfunction

endpackage

// File: rtl/adc_frame_packer_64_capture.sv
// Single-entry hold register between the ADC strobe and the serialiser.
// Timestamps each accepted frame and counts frames lost to a full hold slot.
module adc_frame_packer_64_capture #(
  parameter int FRAME_WIDTH = 256
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_ena,
  input  logic                   i_new_sample,
  input  logic [FRAME_WIDTH-1:0] i_data,
  input  logic                   i_consume,
  input  logic                   i_clear,
  output logic [FRAME_WIDTH-1:0] o_hold_data,
  output logic [31:0]            o_hold_ts,
  output logic                   o_hold_valid,
  output logic [15:0]            o_overrun_cnt
);

  logic [31:0]            r_sample_cnt;
  logic [FRAME_WIDTH-1:0] r_hold_data;
  logic [31:0]            r_hold_ts;
  logic                   r_hold_valid;
  logic [15:0]            r_overrun_cnt;
  logic                   w_load;
  logic                   w_drop;

  // A slot being consumed this cycle counts as free, so back-to-back load and
  // consume never registers as an overrun.
  assign w_load = i_new_sample & i_ena & (~r_hold_valid | i_consume);
  assign w_drop = i_new_sample & i_ena & r_hold_valid & ~i_consume;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sample_cnt  <= '0;
      r_hold_data   <= '0;
      r_hold_ts     <= '0;
      r_hold_valid  <= 1'b0;
      r_overrun_cnt <= '0;
    end else begin
      if (!i_ena) begin
        r_sample_cnt <= '0;
      end else if (i_new_sample) begin
        r_sample_cnt <= r_sample_cnt + 32'd1;
      end

      if (w_load) begin
        r_hold_data  <= i_data;
        r_hold_ts    <= r_sample_cnt;
        r_hold_valid <= 1'b1;
      end else if (i_consume || i_clear) begin
        r_hold_valid <= 1'b0;
      end

      if (w_drop && (r_overrun_cnt != 16'hFFFF)) begin
        r_overrun_cnt <= r_overrun_cnt + 16'd1;
      end
    end
  end

  assign o_hold_data   = r_hold_data;
  assign o_hold_ts     = r_hold_ts;
  assign o_hold_valid  = r_hold_valid;
  assign o_overrun_cnt = r_overrun_cnt;

endmodule

// File: rtl/adc_frame_packer_64.sv
// Packs captured ADC frames into 64-bit AXI4-Stream packets: one header word,
// then SAMPLES_PER_PKT frames of WPS words each, tlast on the final word.
module adc_frame_packer_64
  import adc_frame_packer_64_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int N_CHAN          = 16,
  parameter int CHAN_WIDTH      = 16,
  parameter int SAMPLES_PER_PKT = 511
) (
  input  logic                         data_clk,
  input  logic                         dma_rstn,
  input  logic                         dma_ena,
  input  logic                         new_sample,
  input  logic [N_CHAN*CHAN_WIDTH-1:0] adc_data,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [15:0]                  overrun_cnt,
  output logic [31:0]                  pkt_cnt
);

  localparam int FRAME_WIDTH = N_CHAN * CHAN_WIDTH;
  localparam int WPS         = words_per_frame(N_CHAN, CHAN_WIDTH, DATA_WIDTH);
  localparam int WORD_W      = (WPS > 1) ? $clog2(WPS) : 1;
  localparam int FRAME_W     = (SAMPLES_PER_PKT > 1) ? $clog2(SAMPLES_PER_PKT) : 1;
  localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(WPS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SAMPLES_PER_PKT - 1);

  state_e                 r_state, w_state_next;
  logic [FRAME_WIDTH-1:0] r_shift, w_shift_next;
  logic [WORD_W-1:0]      r_word, w_word_next;
  logic [FRAME_W-1:0]     r_frame, w_frame_next;
  logic [DATA_WIDTH-1:0]  r_tdata, w_tdata_next;
  logic                   r_tvalid, w_tvalid_next;
  logic                   r_tlast, w_tlast_next;
  logic [31:0]            r_pkt_cnt, w_pkt_next;
  logic                   w_consume;
  logic                   w_clear;
  logic                   w_hs;
  logic [FRAME_WIDTH-1:0] w_hold_data;
  logic [31:0]            w_hold_ts;
  logic                   w_hold_valid;

  adc_frame_packer_64_capture #(
    .FRAME_WIDTH (FRAME_WIDTH)
  ) u_capture (
    .i_clk         (data_clk),
    .i_rst_n       (dma_rstn),
    .i_ena         (dma_ena),
    .i_new_sample  (new_sample),
    .i_data        (adc_data),
    .i_consume     (w_consume),
    .i_clear       (w_clear),
    .o_hold_data   (w_hold_data),
    .o_hold_ts     (w_hold_ts),
    .o_hold_valid  (w_hold_valid),
    .o_overrun_cnt (overrun_cnt)
  );

  assign w_hs = r_tvalid & m_axis_tready;

  always_ff @(posedge data_clk or negedge dma_rstn) begin
    if (!dma_rstn) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_word    <= '0;
      r_frame   <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_word    <= w_word_next;
      r_frame   <= w_frame_next;
      r_tdata   <= w_tdata_next;
      r_tvalid  <= w_tvalid_next;
      r_tlast   <= w_tlast_next;
      r_pkt_cnt <= w_pkt_next;
    end
  end

  // The output register only reloads on a transition or a handshake, which
  // keeps tdata/tlast frozen while the downstream FIFO stalls.
  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_word_next   = r_word;
    w_frame_next  = r_frame;
    w_tdata_next  = r_tdata;
    w_tvalid_next = r_tvalid;
    w_tlast_next  = r_tlast;
    w_pkt_next    = r_pkt_cnt;
    w_consume     = 1'b0;
    w_clear       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tvalid_next = 1'b0;
        w_tlast_next  = 1'b0;
        if (!dma_ena) begin
          w_clear = 1'b1;
        end else if (w_hold_valid) begin
          w_state_next  = ST_HEADER;
          w_tdata_next  = {HEADER_MAGIC, r_pkt_cnt[15:0], w_hold_ts};
          w_tvalid_next = 1'b1;
        end
      end
      ST_HEADER: begin
        if (w_hs) begin
          w_consume     = 1'b1;
          w_shift_next  = w_hold_data >> DATA_WIDTH;
          w_tdata_next  = w_hold_data[DATA_WIDTH-1:0];
          w_tvalid_next = 1'b1;
          w_tlast_next  = (WPS == 1) && (SAMPLES_PER_PKT == 1);
          w_word_next   = '0;
          w_frame_next  = '0;
          w_state_next  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          if (r_word != WORD_LAST) begin
            w_word_next  = r_word + WORD_W'(1);
            w_tdata_next = r_shift[DATA_WIDTH-1:0];
            w_shift_next = r_shift >> DATA_WIDTH;
            w_tlast_next = ((r_word + WORD_W'(1)) == WORD_LAST) && (r_frame == FRAME_LAST);
          end else if (r_frame == FRAME_LAST) begin
            w_pkt_next    = r_pkt_cnt + 32'd1;
            w_tvalid_next = 1'b0;
            w_tlast_next  = 1'b0;
            w_state_next  = ST_IDLE;
          end else begin
            w_frame_next  = r_frame + FRAME_W'(1);
            w_tvalid_next = 1'b0;
            w_tlast_next  = 1'b0;
            w_state_next  = ST_WAIT_SAMPLE;
          end
        end
      end
      ST_WAIT_SAMPLE: begin
        w_tvalid_next = 1'b0;
        w_tlast_next  = 1'b0;
        if (dma_ena && w_hold_valid) begin
          w_consume     = 1'b1;
          w_shift_next  = w_hold_data >> DATA_WIDTH;
          w_tdata_next  = w_hold_data[DATA_WIDTH-1:0];
          w_tvalid_next = 1'b1;
          w_tlast_next  = (WPS == 1) && (r_frame == FRAME_LAST);
          w_word_next   = '0;
          w_state_next  = ST_DATA;
        end
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_tvalid_next = 1'b0;
        w_tlast_next  = 1'b0;
      end
    endcase
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = {KEEP_WIDTH{1'b1}};
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign pkt_cnt       = r_pkt_cnt;

endmodule

// File: tb/tb_adc_frame_packer_64.sv
// Scoreboard bench for adc_frame_packer_64: stimulus queues expected stream
// words from a packet-level model, an independent monitor checks handshakes.
module tb_adc_frame_packer_64;

  localparam int SPP = 2;
  localparam int NCH = 16;
  localparam int CW  = 16;
  localparam int FW  = NCH * CW;

  logic          data_clk = 1'b0;
  logic          dma_rstn = 1'b0;
  logic          dma_ena = 1'b0;
  logic          new_sample = 1'b0;
  logic [FW-1:0] adc_data = '0;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [15:0]   overrun_cnt;
  logic [31:0]   pkt_cnt;

  adc_frame_packer_64 #(
    .DATA_WIDTH      (64),
    .KEEP_WIDTH      (8),
    .N_CHAN          (NCH),
    .CHAN_WIDTH      (CW),
    .SAMPLES_PER_PKT (SPP)
  ) dut (
    .data_clk      (data_clk),
    .dma_rstn      (dma_rstn),
    .dma_ena       (dma_ena),
    .new_sample    (new_sample),
    .adc_data      (adc_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overrun_cnt   (overrun_cnt),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 data_clk = ~data_clk;

  logic [64:0] expQ[$];
  int total = 0;
  int bad = 0;
  int sampleIdx = 0;
  int pktNum = 0;
  int framesInPkt = 0;
  int dropCnt = 0;
  int readyMode = 0;
  int zeroRun = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic modelReset();
    sampleIdx   = 0;
    pktNum      = 0;
    framesInPkt = 0;
    dropCnt     = 0;
    expQ.delete();
  endtask

  // Packet-level model: header ahead of a packet's first frame, then the frame
  // split into 64-bit words lowest channel first, tlast on the packet's end.
  task automatic pushFrame(input logic [FW-1:0] frame, input int ts);
    logic [63:0] w;
    logic        l;
    if (framesInPkt == 0) expQ.push_back({1'b0, 16'hADC0, 16'(pktNum), 32'(ts)});
    for (int k = 0; k < FW / 64; k++) begin
      w = frame[64*k +: 64];
      l = (k == FW / 64 - 1) && (framesInPkt == SPP - 1);
      expQ.push_back({l, w});
    end
    framesInPkt++;
    if (framesInPkt == SPP) begin
      framesInPkt = 0;
      pktNum++;
    end
  endtask

  task automatic applyStimulus(input logic [FW-1:0] frame, input bit accept);
    @(posedge data_clk);
    #1;
    new_sample = 1'b1;
    adc_data   = frame;
    if (dma_ena) begin
      if (accept) pushFrame(frame, sampleIdx);
      else dropCnt++;
      sampleIdx++;
    end
    @(posedge data_clk);
    #1;
    new_sample = 1'b0;
  endtask

  function automatic logic [FW-1:0] randFrame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 32; i++) f[32*i +: 32] = $urandom;
    return f;
  endfunction

  task automatic waitDrain(input string name);
    int cycles = 0;
    while (expQ.size() != 0 && cycles < 3000) begin
      @(posedge data_clk);
      cycles++;
    end
    repeat (4) @(posedge data_clk);
    #1;
    checkOutput(name, 64'(expQ.size()), 64'd0);
  endtask

  // Ready driver: always high, bounded random stalls (never more than three
  // low cycles in a row, so spaced strobes cannot overrun), or held low.
  initial begin
    forever begin
      @(posedge data_clk);
      #1;
      case (readyMode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = (zeroRun >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        default: m_axis_tready = 1'b0;
      endcase
      zeroRun = m_axis_tready ? 0 : zeroRun + 1;
    end
  end

  logic [64:0] mExp;
  logic [63:0] prevData;
  logic        prevLast;
  bit          prevStall = 1'b0;

  // Monitor: each handshake must match the scoreboard head; a stalled word
  // must not change until it is accepted.
  always @(negedge data_clk) begin
    if (!dma_rstn) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall && m_axis_tvalid) begin
        checkOutput("stall tdata stable", m_axis_tdata, prevData);
        checkOutput("stall tlast stable", 64'(m_axis_tlast), 64'(prevLast));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected word", m_axis_tdata, 64'hx);
        end else begin
          mExp = expQ.pop_front();
          checkOutput("stream tdata", m_axis_tdata, mExp[63:0]);
          checkOutput("stream tlast", 64'(m_axis_tlast), 64'(mExp[64]));
        end
      end
      prevStall = m_axis_tvalid && !m_axis_tready;
      prevData  = m_axis_tdata;
      prevLast  = m_axis_tlast;
    end
  end

  initial begin
    logic [FW-1:0] f;
    modelReset();
    repeat (3) @(posedge data_clk);
    #1;
    checkOutput("reset tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("reset tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("reset tdata", m_axis_tdata, 64'd0);
    checkOutput("reset overrun_cnt", 64'(overrun_cnt), 64'd0);
    checkOutput("reset pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("tkeep", 64'(m_axis_tkeep), 64'hFF);
    @(posedge data_clk);
    #1;
    dma_rstn = 1'b1;
    dma_ena  = 1'b1;

    // Channel ramp frame then a random frame, full-rate ready.
    for (int i = 0; i < NCH; i++) f[CW*i +: CW] = 16'(16'h0100 + i);
    applyStimulus(f, 1'b1);
    repeat (38) @(posedge data_clk);
    applyStimulus(randFrame(), 1'b1);
    waitDrain("first packet drain");
    checkOutput("pkt_cnt after first packet", 64'(pkt_cnt), 64'(pktNum));

    // Random data with bounded random back-pressure.
    readyMode = 1;
    for (int p = 0; p < 4 * SPP; p++) begin
      applyStimulus(randFrame(), 1'b1);
      repeat (38 + $urandom_range(0, 10)) @(posedge data_clk);
    end
    waitDrain("random packets drain");
    readyMode = 0;
    checkOutput("pkt_cnt after random", 64'(pkt_cnt), 64'(pktNum));
    checkOutput("overrun_cnt after random", 64'(overrun_cnt), 64'(dropCnt));

    // Downstream stalled: first frame holds, the next four are dropped.
    readyMode = 2;
    repeat (2) @(posedge data_clk);
    applyStimulus(randFrame(), 1'b1);
    for (int i = 0; i < 4; i++) begin
      repeat (38) @(posedge data_clk);
      applyStimulus(randFrame(), 1'b0);
    end
    repeat (20) @(posedge data_clk);
    #1;
    checkOutput("overrun_cnt after stall", 64'(overrun_cnt), 64'(dropCnt));
    checkOutput("header held during stall", 64'(m_axis_tvalid), 64'd1);
    readyMode = 0;
    repeat (20) @(posedge data_clk);
    for (int i = 0; i < 1 + SPP; i++) begin
      applyStimulus(randFrame(), 1'b1);
      repeat (38) @(posedge data_clk);
    end
    waitDrain("post-stall drain");
    checkOutput("pkt_cnt after stall", 64'(pkt_cnt), 64'(pktNum));

    // Strobes every 5 clocks: serialiser keeps pace, no overruns.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(randFrame(), 1'b1);
      repeat (3) @(posedge data_clk);
    end
    waitDrain("fast strobe drain");
    checkOutput("overrun_cnt after fast strobes", 64'(overrun_cnt), 64'(dropCnt));
    checkOutput("pkt_cnt after fast strobes", 64'(pkt_cnt), 64'(pktNum));

    // Enable drops after the first frame: packet parks without tlast.
    applyStimulus(randFrame(), 1'b1);
    waitDrain("first half drain");
    dma_ena   = 1'b0;
    sampleIdx = 0;
    repeat (30) @(posedge data_clk);
    #1;
    checkOutput("parked tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("parked pkt_cnt", 64'(pkt_cnt), 64'(pktNum));
    dma_ena = 1'b1;
    repeat (5) @(posedge data_clk);
    applyStimulus(randFrame(), 1'b1);
    waitDrain("resumed packet drain");
    checkOutput("pkt_cnt after resume", 64'(pkt_cnt), 64'(pktNum));

    // Reset mid-packet while the stream is stalled.
    applyStimulus(randFrame(), 1'b1);
    repeat (3) @(posedge data_clk);
    readyMode = 2;
    repeat (3) @(posedge data_clk);
    #3;
    dma_rstn = 1'b0;
    #1;
    checkOutput("async reset tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("async reset tdata", m_axis_tdata, 64'd0);
    checkOutput("async reset pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("async reset overrun_cnt", 64'(overrun_cnt), 64'd0);
    modelReset();
    @(posedge data_clk);
    #1;
    dma_rstn  = 1'b1;
    readyMode = 0;
    for (int i = 0; i < SPP; i++) begin
      applyStimulus(randFrame(), 1'b1);
      repeat (38) @(posedge data_clk);
    end
    waitDrain("post-reset drain");
    checkOutput("pkt_cnt after reset", 64'(pkt_cnt), 64'(pktNum));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
